// File: rtl/spi_resp_pkg.sv
// Shared constants and types for the SPI mode-0 responder.
package spi_resp_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Clamp a requested synchroniser depth to the metastability-safe minimum.
    function automatic int sync_depth(input int req);
        return (req < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : req;
    endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// Multi-stage pin synchroniser with registered edge pulses; level_o is delayed
// one extra cycle so it lines up with rise_o/fall_o.
module spi_resp_sync
    import spi_resp_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DEPTH = sync_depth(STAGES);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic             rise_q;
    logic             fall_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
            prev_q <= sync_q[DEPTH-1];
            rise_q <= sync_q[DEPTH-1] & ~prev_q;
            fall_q <= ~sync_q[DEPTH-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_resp_slave.sv
// SPI mode-0 responder: oversampled pins, MOSI deserialiser, MISO serialiser
// fed from a one-entry holding register with a valid/ready handshake.
module spi_resp_slave
    import spi_resp_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              CS_n,
    output logic              MISO,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_start,
    output logic              frame_abort
);

    localparam int                CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    // CS_n synchroniser resets high so reset release never looks like a frame start.
    spi_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(SCLK),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(CS_n),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(MOSI),
        .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              underrun_q, underrun_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic              load;
    logic              miso_upd;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        underrun_d  = 1'b0;
        start_d     = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;
        miso_upd    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                    miso_upd  = 1'b1;
                    miso_oe_d = 1'b1;
                    start_d   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    // Frame close wins over a coincident SCLK edge; a partial word is dropped.
                    state_d   = ST_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_MAX) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    miso_upd = 1'b1;
                    if (bit_cnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load observes the holding register as it was before this cycle's write.
        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        if (miso_upd) begin
            miso_d = tx_shift_d[DATA_W-1];
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            underrun_q  <= 1'b0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            underrun_q  <= underrun_d;
            start_q     <= start_d;
            abort_q     <= abort_d;
        end
    end

    assign MISO        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = !hold_full_q;
    assign tx_underrun = underrun_q;
    assign frame_start = start_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_resp_slave.sv
// Scoreboard bench for spi_resp_slave: a behavioural SPI controller plus a
// word-level model of the holding register feeding expected-value queues.
module tb_spi_resp_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       CS_n = 1'b1;
    logic       MISO;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_start;
    logic       frame_abort;

    spi_resp_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
        .MISO(MISO), .miso_oe(miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_underrun(tx_underrun), .frame_start(frame_start), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: holding register contents and expected pulse counts.
    bit         m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    int         m_under = 0, m_start = 0, m_abort = 0;
    int         o_under = 0, o_start = 0, o_abort = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    logic [7:0] f_mosi   [8];
    bit         f_wr_en  [8];
    logic [7:0] f_wr_val [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Word boundary: the transmitter takes whatever the holding register has.
    task automatic model_boundary();
        if (m_full) begin
            exp_miso.push_back(m_hold);
            m_full = 1'b0;
        end else begin
            exp_miso.push_back(8'h00);
            m_under++;
        end
    endtask

    task automatic tx_write(input logic [7:0] v);
        check("tx_ready_before_write", {31'd0, tx_ready}, 32'd1);
        tx_data  = v;
        tx_valid = 1'b1;
        clk_n(1);
        tx_valid = 1'b0;
        check("tx_ready_after_write", {31'd0, tx_ready}, 32'd0);
        m_hold = v;
        m_full = 1'b1;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            f_mosi[i]   = 8'h00;
            f_wr_en[i]  = 1'b0;
            f_wr_val[i] = 8'h00;
        end
    endtask

    // stop_mode: 1 = raise CS_n after stop_at rises, 2 = assert rst after stop_at rises.
    task automatic frame(input int nw, input int stop_at, input int stop_mode,
                         input bit exact_wr, input logic [7:0] exact_val);
        int rises;
        rises = 0;
        CS_n = 1'b0;
        model_boundary();
        m_start++;
        if (exact_wr) begin
            clk_n(3);
            check("tx_ready_exact", {31'd0, tx_ready}, 32'd1);
            tx_data  = exact_val;
            tx_valid = 1'b1;
            clk_n(1);
            tx_valid = 1'b0;
            m_hold = exact_val;
            m_full = 1'b1;
            clk_n(2);
        end else begin
            clk_n(6);
        end
        for (int w = 0; w < nw; w++) begin
            for (int b = 7; b >= 0; b--) begin
                MOSI = f_mosi[w][b];
                if (b == 4 && f_wr_en[w] && !m_full) begin
                    tx_write(f_wr_val[w]);
                    clk_n(3);
                end else begin
                    clk_n(4);
                end
                SCLK = 1'b1;
                rises++;
                if (b == 0) exp_rx.push_back(f_mosi[w]);
                if (rises == stop_at) begin
                    clk_n(2);
                    if (stop_mode == 1) begin
                        CS_n = 1'b1;
                        clk_n(1);
                        SCLK = 1'b0;
                        m_abort++;
                        exp_miso.delete();
                        clk_n(8);
                    end else begin
                        rst = 1'b1;
                        #1;
                        check("rst_MISO",        {31'd0, MISO},        32'd0);
                        check("rst_miso_oe",     {31'd0, miso_oe},     32'd0);
                        check("rst_rx_data",     {24'd0, rx_data},     32'd0);
                        check("rst_rx_valid",    {31'd0, rx_valid},    32'd0);
                        check("rst_tx_ready",    {31'd0, tx_ready},    32'd1);
                        check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
                        check("rst_frame_start", {31'd0, frame_start}, 32'd0);
                        check("rst_frame_abort", {31'd0, frame_abort}, 32'd0);
                        CS_n = 1'b1;
                        SCLK = 1'b0;
                        MOSI = 1'b0;
                        clk_n(2);
                        rst = 1'b0;
                        m_full = 1'b0;
                        exp_miso.delete();
                        clk_n(4);
                    end
                    return;
                end
                clk_n(4);
                if (w == nw - 1 && b == 0) begin
                    CS_n = 1'b1;
                    clk_n(1);
                    SCLK = 1'b0;
                end else begin
                    SCLK = 1'b0;
                    if (b == 0) model_boundary();
                end
            end
        end
        clk_n(8);
    endtask

    // Monitor: received words and output pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got %0h expected no word (t=%0t)", rx_data, $time);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
                end
            end
            if (tx_underrun) o_under++;
            if (frame_start) o_start++;
            if (frame_abort) o_abort++;
        end
    end

    // Monitor: MISO sampled by the controller on each SCLK rise inside a frame.
    int         mbits = 0;
    logic [7:0] mword = 8'h00;
    always @(posedge SCLK or negedge CS_n) begin
        if (!SCLK) begin
            mbits = 0;
        end else if (!CS_n) begin
            mword = {mword[6:0], MISO};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                check("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
                if (exp_miso.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL miso_unexpected: got %0h expected no word (t=%0t)", mword, $time);
                end else begin
                    check("miso_word", {24'd0, mword}, {24'd0, exp_miso.pop_front()});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_frame();
        #1;
        check("reset_MISO",     {31'd0, MISO},     32'd0);
        check("reset_miso_oe",  {31'd0, miso_oe},  32'd0);
        check("reset_rx_data",  {24'd0, rx_data},  32'd0);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        clk_n(3);
        rst = 1'b0;
        clk_n(4);

        // Single word with preloaded response.
        tx_write(8'hA5);
        clear_frame();
        f_mosi[0] = 8'h3C;
        frame(1, 0, 0, 1'b0, 8'h00);
        check("underrun_after_single", o_under, m_under);
        check("start_after_single", o_start, m_start);

        // Three-word burst; second word written mid-frame, third underruns.
        tx_write(8'h11);
        clear_frame();
        f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
        f_wr_en[0] = 1'b1; f_wr_val[0] = 8'h22;
        frame(3, 0, 0, 1'b0, 8'h00);
        check("underrun_after_burst", o_under, m_under);

        // Abort after five rises, then a clean 0xFF frame.
        clear_frame();
        f_mosi[0] = 8'hB6;
        frame(1, 5, 1, 1'b0, 8'h00);
        check("abort_count", o_abort, m_abort);
        clear_frame();
        f_mosi[0] = 8'hFF;
        frame(1, 0, 0, 1'b0, 8'h00);

        // Write lands in the very cycle of the frame-start load.
        clear_frame();
        f_mosi[0] = 8'h9E; f_mosi[1] = 8'h4D;
        frame(2, 0, 0, 1'b1, 8'h77);
        check("underrun_after_exact", o_under, m_under);

        // Reset mid-word, then a fresh exchange.
        tx_write(8'h99);
        clear_frame();
        f_mosi[0] = 8'hE1;
        frame(1, 4, 2, 1'b0, 8'h00);
        tx_write(8'hC3);
        clear_frame();
        f_mosi[0] = 8'h5A;
        frame(1, 0, 0, 1'b0, 8'h00);

        // SCLK activity with CS_n high must be ignored.
        tx_write(8'h3E);
        for (int i = 0; i < 16; i++) begin
            SCLK = ~SCLK;
            MOSI = 1'($urandom_range(0, 1));
            clk_n(4);
            if (i % 4 == 3) check("idle_miso_oe", {31'd0, miso_oe}, 32'd0);
        end
        SCLK = 1'b0;
        clk_n(6);
        check("idle_hold_kept", {31'd0, tx_ready}, {31'd0, !m_full});
        clear_frame();
        f_mosi[0] = 8'h81;
        frame(1, 0, 0, 1'b0, 8'h00);

        // Randomised frames.
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            clear_frame();
            for (int w = 0; w < 8; w++) begin
                f_mosi[w]   = 8'($urandom);
                f_wr_en[w]  = 1'($urandom_range(0, 1));
                f_wr_val[w] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1 && !m_full) tx_write(8'($urandom));
            frame(nw, 0, 0, 1'b0, 8'h00);
        end

        clk_n(10);
        check("final_underrun_count", o_under, m_under);
        check("final_start_count", o_start, m_start);
        check("final_abort_count", o_abort, m_abort);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("miso_queue_drained", exp_miso.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_resp_slave.md
# spi_resp_slave

SPI mode-0 responder: the device-side end of the four SPI links driven by the Drone Cam controller (SCLK/MOSI/CS_n out, MISO in). It oversamples the SPI pins in the local clock domain, deserialises MOSI into bytes, and serialises a byte stream onto MISO through a one-entry holding register with a valid/ready handshake. It sits on the peripheral/loopback FPGA side, or in the bench as the link partner for each controller channel.

## Interface
- DATA_W, 8: bits per SPI word, MSB first.
- SYNC_STAGES, 2: synchroniser depth for SCLK, MOSI, CS_n (minimum 2).
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- rst  input  1  reset; asynchronous, active-high.
- SCLK  input  1  SPI clock from the controller, idle low (CPOL=0).
- MOSI  input  1  controller-to-responder data.
- CS_n  input  1  active-low frame select.
- MISO  output  1  responder-to-controller data.
- miso_oe  output  1  MISO drive enable; high only while a frame is open.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_data  input  DATA_W  next word to transmit.
- tx_valid  input  1  tx_data is offered.
- tx_ready  output  1  holding register empty.
- tx_underrun  output  1  one-cycle pulse: word boundary reached with holding register empty.
- frame_start  output  1  one-cycle pulse on synchronised CS_n fall.
- frame_abort  output  1  one-cycle pulse on CS_n rise with a partial word.

## Operation
- States: IDLE (CS_n high), ACTIVE (CS_n low). IDLE->ACTIVE on synchronised CS_n fall; ACTIVE->IDLE on synchronised CS_n rise.
- On IDLE->ACTIVE: bit_cnt=0; load tx shifter (see load rule); MISO=shifter MSB; miso_oe=1; frame_start pulse.
- SCLK rise in ACTIVE: rx_shift={rx_shift[DATA_W-2:0], MOSI_s}; bit_cnt++ (wraps DATA_W-1 -> 0). When bit_cnt was DATA_W-1: rx_data=completed word, rx_valid pulses next cycle.
- SCLK fall in ACTIVE: if bit_cnt==0 (word boundary), load tx shifter; else shift left. MISO=shifter MSB.
- Load rule: holding full -> shifter=holding, holding cleared. Holding empty -> shifter=0, tx_underrun pulse.
- tx handshake: transfer when tx_valid && tx_ready; tx_ready = !holding_full. Load and write in same cycle: load sees pre-write contents; written word stays in holding for the next boundary.
- CS_n rise with bit_cnt!=0: partial word discarded, no rx_valid, frame_abort pulse. Holding register untouched.
- Edges while IDLE ignored. In IDLE: MISO=0, miso_oe=0.
- Reset mid-frame: all state returns to reset values immediately; next frame requires a fresh CS_n fall.

## Timing
- Reset values: MISO 0, miso_oe 0, rx_data 0, rx_valid 0, tx_ready 1, tx_underrun 0, frame_start 0, frame_abort 0, state IDLE, bit_cnt 0.
- Pin-to-detect latency: SYNC_STAGES+1 clk cycles from any pin edge.
- MISO first bit valid SYNC_STAGES+2 clk after CS_n fall; controller must allow >=4 clk before first SCLK rise.
- MISO update SYNC_STAGES+2 clk after SCLK fall; rx_valid SYNC_STAGES+2 clk after the DATA_W-th SCLK rise.
- tx_ready falls the cycle after an accepted write; rises the cycle after a load.
- Back-to-back words: no gap required; bit_cnt wraps, next word continues.

## Structure
- Package spi_resp_pkg: state enum {IDLE, ACTIVE}, DATA_W default, SYNC_STAGES minimum constant.
- Sub-module spi_resp_sync: SYNC_STAGES-deep synchroniser plus registered rise/fall pulse outputs; three instances (SCLK, CS_n, MOSI; edges unused for MOSI).
- Top holds FSM, bit counter, rx/tx shifters, holding register.

## Test plan
- Preload tx 0xA5, frame of one word MOSI 0x3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data 0x3C, one rx_valid pulse, frame_start once, no underrun.
- Three-word burst MOSI 0x01,0x02,0x03, tx 0x11,0x22 written on tx_ready -> rx 0x01,0x02,0x03 in order; MISO 0x11,0x22,0x00 with one tx_underrun at third boundary.
- CS_n raised after 5 SCLK rises -> no rx_valid, frame_abort pulse, next full frame with 0xFF received correctly.
- tx_valid asserted in the exact load cycle with holding empty -> word 0x00 sent plus underrun; written 0x77 sent as next word.
- rst asserted mid-word at bit 4 -> all outputs at reset values same cycle; subsequent frame 0x5A/0xC3 exchanged correctly.
- SCLK toggling with CS_n high -> no rx_valid, miso_oe stays 0, holding register unchanged.
